seq_frame_tx: RTL
=================

Name: seq_frame_tx

Overview:
- Serial frame generator; the transmit end of the team's serial sequence-detection path.
- Accepts a parallel payload word via a ready/start handshake.
- Emits one bit per clock: a fixed sync pattern (default 1101), then the payload MSB-first, then a fixed idle gap.
- Drives the serial input of the downstream sequence detector and of the bit-level test benches.

Parameters:
- DATA_W, 8: payload width in bits.
- SYNC_W, 4: sync pattern width in bits.
- SYNC_PAT, 4'b1101: sync pattern, sent MSB-first.
- GAP_CYCLES, 2: idle-bit cycles after each frame before ready reasserts; legal range 0..15.
- IDLE_BIT, 1'b0: line level whenever no frame bit is being driven.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send; accepted only in a cycle where ready=1.
- data  input  DATA_W  payload; sampled only in the accept cycle.
- ready  output  1  block is idle and will accept start this cycle.
- out  output  1  serial bit (registered).
- out_valid  output  1  out carries a frame bit (sync or payload).
- sync_phase  output  1  out carries a sync bit.
- done  output  1  one-cycle pulse, coincident with the last payload bit.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- All outputs are registered. Reset values: ready=1, out=IDLE_BIT, out_valid=0, sync_phase=0, done=0, state=IDLE, counters=0.
- FSM states and transitions:
  - IDLE -> SYNC on start&&ready.
  - SYNC -> DATA after SYNC_W bits.
  - DATA -> GAP after DATA_W bits (-> IDLE directly if GAP_CYCLES=0).
  - GAP -> IDLE after GAP_CYCLES cycles.
- Accept in cycle N:
  - data is latched into the shift register; ready=0 from N+1.
  - Cycles N+1..N+SYNC_W: out=SYNC_PAT[SYNC_W-1..0], out_valid=1, sync_phase=1.
  - Cycles N+SYNC_W+1..N+SYNC_W+DATA_W: out=data[DATA_W-1..0], out_valid=1, sync_phase=0.
  - done=1 only in cycle N+SYNC_W+DATA_W.
- GAP: out=IDLE_BIT, out_valid=0, ready=0 for exactly GAP_CYCLES cycles. ready=1 in the following cycle.
- Minimum frame spacing with start held high: SYNC_W+DATA_W+GAP_CYCLES+1 cycles between accept cycles.
- start while ready=0 is ignored; it is not queued.
- data changes after the accept cycle have no effect on the frame in flight.
- Reset mid-frame or mid-gap: next cycle all outputs return to reset values and the frame is abandoned, with no done pulse.
- reset and start in the same cycle: reset wins; start is not accepted.
- Bit counter width: clog2(max(SYNC_W, DATA_W, GAP_CYCLES)+1). It must not wrap within a phase.
- A payload may itself contain the sync pattern. The block does not escape it; framing is the detector's responsibility.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, SYNC=2'b01, DATA=2'b10, GAP=2'b11), default SYNC_PAT, IDLE_BIT.
- The receiver side imports the same SYNC_PAT constant.
- One natural sub-module: piso_shift_reg, a parallel-load, MSB-first serial-out register with load/shift enables, width DATA_W. FSM and counters stay in the top.

Test Plan:
- Reset, then start=1 with data=8'hA5: out over 12 cycles = 1,1,0,1,1,0,1,0,0,1,0,1. sync_phase high for the first 4 cycles only. done pulses on bit 12. Then 2 idle cycles with out=0, then ready=1.
- start held high with data=8'h3C for two frames: accepts exactly 15 cycles apart. The second frame is 1101_00111100. out_valid low for exactly 2 cycles between frames.
- start pulsed during the SYNC and DATA phases of a frame with data=8'hFF: pulses ignored, payload unchanged, no extra frame.
- data changed from 8'h81 to 8'h00 in the cycle after accept: transmitted payload bits = 1,0,0,0,0,0,0,1.
- reset asserted during payload bit 3 of a frame: next cycle out=0, out_valid=0, ready=1, no done. A new start is accepted immediately.
- GAP_CYCLES=0 build, back-to-back frames: ready=1 in the cycle after done, giving a 13-cycle accept spacing.

Source files
------------

// File: rtl/seq_frame_tx_pkg.sv
// rtl/seq_frame_tx_pkg.sv - shared framing constants and state encoding for the serial frame path
package seq_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SYNC = 2'b01,
        ST_DATA = 2'b10,
        ST_GAP  = 2'b11
    } state_t;

    // The receiving detector imports this same constant so both ends agree on framing.
    localparam logic [3:0] SYNC_PAT_DEFAULT = 4'b1101;
    localparam logic       IDLE_BIT_DEFAULT = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_frame_tx_piso_shift_reg.sv
// rtl/seq_frame_tx_piso_shift_reg.sv - parallel-load, MSB-first serial-out shift register
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame generator: sync pattern, MSB-first payload, idle gap
module seq_frame_tx
    import seq_frame_tx_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                SYNC_W     = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_PAT_DEFAULT,
    parameter int                GAP_CYCLES = 2,
    parameter logic              IDLE_BIT   = IDLE_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              out,
    output logic              out_valid,
    output logic              sync_phase,
    output logic              done
);

    localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              out_n, valid_n, sync_n, done_n, ready_n;
    logic              load, shift, sr_msb;
    logic [SYNC_W-1:0] sync_sh;

    piso_shift_reg #(.WIDTH(DATA_W)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .data  (data),
        .msb   (sr_msb)
    );

    // cnt holds the number of bits of the current phase already on the line.
    assign sync_sh = SYNC_PAT << cnt;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = IDLE_BIT;
        valid_n = 1'b0;
        sync_n  = 1'b0;
        done_n  = 1'b0;
        ready_n = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_n = 1'b1;
                cnt_n   = '0;
                if (start && ready) begin
                    state_n = ST_SYNC;
                    cnt_n   = CNT_ONE;
                    out_n   = SYNC_PAT[SYNC_W-1];
                    valid_n = 1'b1;
                    sync_n  = 1'b1;
                    load    = 1'b1;
                    ready_n = 1'b0;
                end
            end
            ST_SYNC: begin
                valid_n = 1'b1;
                if (cnt != SYNC_LAST) begin
                    cnt_n  = cnt + CNT_ONE;
                    out_n  = sync_sh[SYNC_W-1];
                    sync_n = 1'b1;
                end else begin
                    state_n = ST_DATA;
                    cnt_n   = CNT_ONE;
                    out_n   = sr_msb;
                    shift   = 1'b1;
                    done_n  = (DATA_W == 1);
                end
            end
            ST_DATA: begin
                if (cnt != DATA_LAST) begin
                    cnt_n   = cnt + CNT_ONE;
                    out_n   = sr_msb;
                    shift   = 1'b1;
                    valid_n = 1'b1;
                    done_n  = (cnt_n == DATA_LAST);
                end else if (GAP_CYCLES == 0) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    ready_n = 1'b1;
                end else begin
                    state_n = ST_GAP;
                    cnt_n   = CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt != GAP_LAST) begin
                    cnt_n = cnt + CNT_ONE;
                end else begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    ready_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ready      <= 1'b1;
            out        <= IDLE_BIT;
            out_valid  <= 1'b0;
            sync_phase <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ready      <= ready_n;
            out        <= out_n;
            out_valid  <= valid_n;
            sync_phase <= sync_n;
            done       <= done_n;
        end
    end

endmodule
